// File: rtl/cpu_pkg.sv
// Shared datapath defaults and the helper used to locate a port's field
// inside a flattened multi-port vector.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam bit          ZERO_REG_DEF   = 1'b1;

  // Low bit of field `idx` in a vector packed as idx*width +: width.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, its registered popcount,
// and per-read-port busy flags that already account for completing writes.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 2,
  parameter bit          ZERO_REG   = ZERO_REG_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_WRITE-1:0]           wr_eff,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic [NUM_READ-1:0]            rd_busy,
  output logic [(1<<ADDR_WIDTH)-1:0]     busy_vec,
  output logic [ADDR_WIDTH:0]            busy_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_WIDTH:0] count_q, count_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      logic wr_hit;
      logic rsv_hit;

      always_comb begin
        wr_hit = 1'b0;
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_eff[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(gi))) begin
            wr_hit = 1'b1;
          end
        end
      end

      assign rsv_hit = rsv_en && (rsv_addr == ADDR_WIDTH'(gi)) && !(ZERO_REG && (gi == 0));
      // A new reservation outranks a completing write: another producer is now in flight.
      assign busy_d[gi] = rsv_hit | (busy_q[gi] & ~wr_hit);
    end
  endgenerate

  always_comb begin
    count_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      count_d = count_d + {{ADDR_WIDTH{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd_busy
      logic [ADDR_WIDTH-1:0] ra;
      logic                  wr_hit;

      assign ra = rd_addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];

      always_comb begin
        wr_hit = 1'b0;
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_eff[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
            wr_hit = 1'b1;
          end
        end
      end

      assign rd_busy[gi] = busy_q[ra] && !wr_hit && !(ZERO_REG && (ra == '0));
    end
  endgenerate

  assign busy_vec   = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with same-cycle write-to-read bypass, a pending-write
// scoreboard for RAW hazard detection, and a debug tap on one register.
module register_file_mp
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 2,
  parameter bit          ZERO_REG   = ZERO_REG_DEF,
  parameter int unsigned DEBUG_REG  = 26
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]             rd_busy,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic                            rsv_en,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr,
  output logic [(1<<ADDR_WIDTH)-1:0]      busy_vec,
  output logic [ADDR_WIDTH:0]             busy_count,
  output logic [DATA_WIDTH-1:0]           debug_out
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [NUM_WRITE-1:0]  wr_eff;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WRITE; gi++) begin : g_wr_eff
      assign wr_eff[gi] = wr_en[gi] &&
                          !(ZERO_REG && (wr_addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH] == '0));
    end
  endgenerate

  // Ports applied in ascending order so the highest-index port wins a conflict.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_eff[w]) begin
        mem_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_q[r] <= rst ? '0 : mem_d[r];
    end
  end

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rdat;

      assign ra = rd_addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH];

      always_comb begin
        rdat = mem_q[ra];
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_eff[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
            rdat = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (ZERO_REG && (ra == '0)) begin
          rdat = '0;
        end
      end

      assign rd_data[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH] = rdat;
    end
  endgenerate

  assign debug_out = mem_q[ADDR_WIDTH'(DEBUG_REG)];

  regfile_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .wr_eff    (wr_eff),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rd_busy   (rd_busy),
    .busy_vec  (busy_vec),
    .busy_count(busy_count)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default-configured instance for bypass/zero-reg/scoreboard
// behaviour, plus a 64-bit/16-entry/3-read instance for the debug tap and wide reads.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [1:0]  wr_en_a;
  logic [9:0]  wr_addr_a;
  logic [63:0] wr_data_a;
  logic        rsv_en_a;
  logic [4:0]  rsv_addr_a;
  logic [31:0] busy_vec_a;
  logic [5:0]  busy_count_a;
  logic [31:0] debug_a;

  // Instance B: 64-bit data, 16 entries, 3 read ports, debug on r10
  logic [11:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic [2:0]   rd_busy_b;
  logic [1:0]   wr_en_b;
  logic [7:0]   wr_addr_b;
  logic [127:0] wr_data_b;
  logic         rsv_en_b;
  logic [3:0]   rsv_addr_b;
  logic [15:0]  busy_vec_b;
  logic [4:0]   busy_count_b;
  logic [63:0]  debug_b;

  register_file_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2),
    .ZERO_REG(1'b1), .DEBUG_REG(26)
  ) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a),
    .busy_vec(busy_vec_a), .busy_count(busy_count_a), .debug_out(debug_a)
  );

  register_file_mp #(
    .DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3), .NUM_WRITE(2),
    .ZERO_REG(1'b1), .DEBUG_REG(10)
  ) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b),
    .busy_vec(busy_vec_b), .busy_count(busy_count_b), .debug_out(debug_b)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] mdl_b [16];

  task automatic expect_val(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    string       tag;
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    tag = tag_q.pop_front();
    e   = exp_q.pop_front();
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0; rsv_en_a = 1'b0; rsv_addr_a = '0;
    wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; rsv_en_b = 1'b0; rsv_addr_b = '0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset state
    rd_addr_a = {5'd2, 5'd1};
    expect_val("reset_rd0", 64'h0);
    expect_val("reset_rd1", 64'h0);
    expect_val("reset_busy_vec", 64'h0);
    expect_val("reset_busy_count", 64'h0);
    expect_val("reset_debug", 64'h0);
    expect_val("reset_rd_busy", 64'h0);
    #1;
    check(rd_data_a[31:0]);
    check(rd_data_a[63:32]);
    check(busy_vec_a);
    check(busy_count_a);
    check(debug_a);
    check(rd_busy_a);

    // Write r5, reserve r7, then reset clears both
    wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'h0, 32'hDEADBEEF};
    rsv_en_a = 1'b1; rsv_addr_a = 5'd7;
    step();
    idle();
    rd_addr_a = {5'd7, 5'd5};
    expect_val("pre_rst_rd_r5", 64'hDEADBEEF);
    expect_val("pre_rst_busy_vec", 64'h80);
    expect_val("pre_rst_count", 64'd1);
    expect_val("pre_rst_rd_busy_r7", 64'd1);
    #1;
    check(rd_data_a[31:0]);
    check(busy_vec_a);
    check(busy_count_a);
    check(rd_busy_a[1]);
    rst = 1'b1;
    wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'h0, 32'h12345678};
    rsv_en_a = 1'b1; rsv_addr_a = 5'd8;
    step();
    rst = 1'b0;
    idle();
    expect_val("post_rst_rd_r5", 64'h0);
    expect_val("post_rst_busy_vec", 64'h0);
    expect_val("post_rst_count", 64'h0);
    #1;
    check(rd_data_a[31:0]);
    check(busy_vec_a);
    check(busy_count_a);

    // Bypass priority: both ports target r9, port 1 wins
    wr_en_a = 2'b11; wr_addr_a = {5'd9, 5'd9}; wr_data_a = {32'h22, 32'h11};
    rd_addr_a = {5'd0, 5'd9};
    expect_val("bypass_rd0", 64'h22);
    #1;
    check(rd_data_a[31:0]);
    step();
    idle();
    expect_val("conflict_mem9", 64'h22);
    #1;
    check(rd_data_a[31:0]);

    // Zero register ignores write and reserve
    wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd0}; wr_data_a = {32'h0, 32'h5};
    rsv_en_a = 1'b1; rsv_addr_a = 5'd0;
    rd_addr_a = {5'd0, 5'd0};
    expect_val("zero_bypass_rd", 64'h0);
    #1;
    check(rd_data_a[31:0]);
    step();
    idle();
    expect_val("zero_rd", 64'h0);
    expect_val("zero_rd_busy", 64'h0);
    expect_val("zero_busy_vec", 64'h0);
    expect_val("zero_count", 64'h0);
    #1;
    check(rd_data_a[31:0]);
    check(rd_busy_a);
    check(busy_vec_a);
    check(busy_count_a);

    // Scoreboard: reserve r3, then complete it with a port-1 write
    rsv_en_a = 1'b1; rsv_addr_a = 5'd3;
    step();
    idle();
    rd_addr_a = {5'd3, 5'd0};
    expect_val("rsv3_count", 64'd1);
    expect_val("rsv3_busy_vec", 64'h8);
    expect_val("rsv3_rd_busy1", 64'd1);
    #1;
    check(busy_count_a);
    check(busy_vec_a);
    check(rd_busy_a[1]);
    wr_en_a = 2'b10; wr_addr_a = {5'd3, 5'd0}; wr_data_a = {32'h77, 32'h0};
    expect_val("wr3_same_cycle_rd_busy1", 64'd0);
    expect_val("wr3_same_cycle_rd_data1", 64'h77);
    expect_val("wr3_same_cycle_busy_vec", 64'h8);
    #1;
    check(rd_busy_a[1]);
    check(rd_data_a[63:32]);
    check(busy_vec_a);
    step();
    idle();
    expect_val("wr3_busy_vec", 64'h0);
    expect_val("wr3_count", 64'h0);
    expect_val("wr3_rd_data1", 64'h77);
    #1;
    check(busy_vec_a);
    check(busy_count_a);
    check(rd_data_a[63:32]);

    // Reserve and write same register: reserve wins, data stored
    rsv_en_a = 1'b1; rsv_addr_a = 5'd4;
    wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd4}; wr_data_a = {32'h0, 32'hA};
    step();
    idle();
    rd_addr_a = {5'd0, 5'd4};
    expect_val("rsvwr4_busy_vec", 64'h10);
    expect_val("rsvwr4_rd_data0", 64'hA);
    expect_val("rsvwr4_rd_busy0", 64'd1);
    expect_val("rsvwr4_count", 64'd1);
    #1;
    check(busy_vec_a);
    check(rd_data_a[31:0]);
    check(rd_busy_a[0]);
    check(busy_count_a);

    // Re-reserve busy r4 and write non-busy r6: count unchanged
    rsv_en_a = 1'b1; rsv_addr_a = 5'd4;
    wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd6}; wr_data_a = {32'h0, 32'h66};
    step();
    idle();
    rd_addr_a = {5'd4, 5'd6};
    expect_val("rersv_busy_vec", 64'h10);
    expect_val("rersv_count", 64'd1);
    expect_val("nonbusy_wr_rd6", 64'h66);
    expect_val("nonbusy_rd_busy0", 64'd0);
    #1;
    check(busy_vec_a);
    check(busy_count_a);
    check(rd_data_a[31:0]);
    check(rd_busy_a[0]);

    // Debug tap on r26 has no bypass
    wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd26}; wr_data_a = {32'h0, 32'hCAFEF00D};
    expect_val("debug_a_no_bypass", 64'h0);
    #1;
    check(debug_a);
    step();
    idle();
    expect_val("debug_a_after", 64'hCAFEF00D);
    #1;
    check(debug_a);

    // Wide instance: debug register
    for (int r = 0; r < 16; r++) mdl_b[r] = 64'h0;
    wr_en_b = 2'b01; wr_addr_b = {4'd0, 4'd10};
    wr_data_b = {64'h0, 64'h0123456789ABCDEF};
    expect_val("debug_b_no_bypass", 64'h0);
    #1;
    check(debug_b);
    step();
    idle();
    mdl_b[10] = 64'h0123456789ABCDEF;
    expect_val("debug_b_after", 64'h0123456789ABCDEF);
    #1;
    check(debug_b);

    // Wide instance: fill registers, then random 3-port reads
    for (int k = 0; k < 8; k++) begin
      logic [63:0] d0, d1;
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      wr_en_b   = 2'b11;
      wr_addr_b = {4'(2*k+1), 4'(2*k)};
      wr_data_b = {d1, d0};
      step();
      if (k != 0) mdl_b[2*k] = d0;
      mdl_b[2*k+1] = d1;
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] a0, a1, a2;
      a0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      a2 = 4'($urandom_range(0, 15));
      rd_addr_b = {a2, a1, a0};
      expect_val($sformatf("wide_rd0_r%0d", a0), mdl_b[a0]);
      expect_val($sformatf("wide_rd1_r%0d", a1), mdl_b[a1]);
      expect_val($sformatf("wide_rd2_r%0d", a2), mdl_b[a2]);
      #1;
      check(rd_data_b[63:0]);
      check(rd_data_b[127:64]);
      check(rd_data_b[191:128]);
      step();
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file for the CPU datapath, with NUM_READ combinational read ports and NUM_WRITE synchronous write ports.
- Same-cycle write-to-read bypass on every read port.
- Per-register pending-write scoreboard (busy bits) so issue logic can detect RAW hazards from multi-cycle producers (loads, mul/div).
- Provides a debug tap on one configurable register.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 2, number of write ports (1..2).
- ZERO_REG, 1, if 1, register 0 reads 0, ignores writes and is never busy.
- DEBUG_REG, 26, index driven on debug_out.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*DATA_WIDTH  read data, combinational.
- rd_busy  out  NUM_READ  1 = addressed register has a pending, unsatisfied write.
- wr_en  in  NUM_WRITE  write enables.
- wr_addr  in  NUM_WRITE*ADDR_WIDTH  write addresses.
- wr_data  in  NUM_WRITE*DATA_WIDTH  write data.
- rsv_en  in  1  reserve (mark busy) request from issue stage.
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- busy_vec  out  DEPTH  registered busy bits.
- busy_count  out  ADDR_WIDTH+1  registered count of set busy bits.
- debug_out  out  DATA_WIDTH  registered-array value of mem[DEBUG_REG]; no bypass.

Behaviour:
- Reset: when rst=1 at posedge, all mem entries are cleared to 0, busy_vec to 0 and busy_count to 0. Reset overrides any simultaneous write or reserve.
- Outputs after reset: rd_data=0, rd_busy=0, debug_out=0 (absent same-cycle writes).
- Effective write: port w is effective when wr_en[w]=1 and, if ZERO_REG=1, wr_addr[w]!=0.
- Write: each effective port updates mem[wr_addr[w]] at posedge, with 1-cycle latency into the array.
- Write conflict: if two effective ports target the same address, the higher index wins, for both the array update and bypass.
- Read: rd_data[i] is combinational from rd_addr[i]. Priority:
  - 0 if ZERO_REG=1 and the address is 0;
  - else wr_data of the highest-index effective write port matching the address (bypass);
  - else mem[addr].
- Scoreboard next state for busy[r]:
  - set if rsv_en and rsv_addr==r (and not (ZERO_REG and r==0));
  - else cleared if any effective write targets r;
  - else held.
  - Reserve and write to the same register in one cycle: reserve wins (a new producer is pending). The write data is still stored.
- rd_busy[i] = busy[rd_addr[i]] AND no effective write to rd_addr[i] this cycle. A completing write is therefore visible as not-busy with bypassed data in the same cycle.
- rd_busy[i] is 0 for address 0 when ZERO_REG=1.
- busy_count is the popcount of the next-state busy vector, registered, so it is always consistent with busy_vec. It saturates naturally at DEPTH-ZERO_REG.
- A write to a non-busy register is legal and leaves busy untouched.
- Reserving an already-busy register is legal; busy stays at 1 and the count is unchanged.
- There are no handshakes or stalls; the block always accepts its inputs.

Decomposition:
- Shared package (cpu_pkg): DATA_WIDTH/ADDR_WIDTH defaults, ZERO_REG constant, and a function for slicing a flattened port vector.
- Sub-module regfile_scoreboard: owns busy_vec, busy_count and the rd_busy generation. The main module owns the storage array, write arbitration and the bypass muxes.

Test Plan:
- Reset: write 0xDEADBEEF to r5, reserve r7, assert rst for 1 cycle. Then rd r5 -> 0, busy_vec=0, busy_count=0.
- Bypass priority: wr_en=2'b11, wr_addr both 9, data 0x11/0x22, rd_addr0=9 in the same cycle. Then rd_data0=0x22 combinationally, and mem[9]=0x22 next cycle.
- Zero register: write 0x5 to r0 and reserve r0. Then rd r0 -> 0, rd_busy=0, busy_count unchanged.
- Scoreboard: reserve r3 (count -> 1); next cycle rd r3 -> rd_busy=1. Write r3=0x77 on port 1 -> same-cycle rd_busy=0, rd_data=0x77; next cycle busy_vec[3]=0, count=0.
- Simultaneous reserve and write: rsv r4 and wr r4=0xA in one cycle. Next cycle busy[4]=1, mem[4]=0xA, rd_busy=1.
- Debug/width sweep: DATA_WIDTH=64, ADDR_WIDTH=4, NUM_READ=3. Write 0x0123456789ABCDEF to DEBUG_REG=10 -> debug_out equals it one cycle later. All 3 read ports return correct data for randomly chosen addresses.
